// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM stage: control-bit positions, FSM encoding
// and the packed EX/MEM request that is held while a RAM access is in flight.
package memory_access_stage_pkg;

  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } memState_t;

  typedef struct packed {
    logic [1:0]  wbCtl;
    logic [1:0]  memCtl;
    logic [31:0] result;
    logic [31:0] writeData;
    logic [4:0]  rd;
  } exMemReg_t;

endpackage

// File: rtl/memory_access_stage_data_memory.sv
// Word-addressed 32b data RAM: combinational read, falling-edge write.
// No backpressure; a read in the same edge as a write sees the old word.
module data_memory #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData
);

  logic [31:0] ram [2**ADDR_WIDTH];

  assign readData = ram[address];

  always_ff @(negedge clk) begin
    if (writeEnable) begin
      ram[address] <= writeData;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: each load/store takes MEM_LATENCY+1 cycles, stalling upstream
// for MEM_LATENCY of them; non-memory ops pass to MEM/WB every falling edge.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  writeBackControlIn,
  input  logic [1:0]  memAccessControlIn,
  input  logic [31:0] resultIn,
  input  logic [31:0] writeDataIn,
  input  logic [4:0]  rdIn,
  output logic        stall,
  output logic [1:0]  writeBackControlOut,
  output logic [31:0] readDataOut,
  output logic [31:0] resultOut,
  output logic [4:0]  rdOut,
  output logic        memWbRegWrite,
  output logic [4:0]  memWbRd,
  output logic [31:0] memWbData
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  memState_t             state;
  logic [CNT_W-1:0]      counter;
  exMemReg_t             inReq;
  exMemReg_t             heldReq;
  exMemReg_t             curReq;
  logic                  access;
  logic                  complete;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memIndex;
  logic [31:0]           ramData;

  assign inReq = '{wbCtl: writeBackControlIn, memCtl: memAccessControlIn,
                   result: resultIn, writeData: writeDataIn, rd: rdIn};

  assign access   = inReq.memCtl[MEMREAD] | inReq.memCtl[MEMWRITE];
  assign curReq   = (state == BUSY) ? heldReq : inReq;
  assign complete = (state == BUSY) ? (counter == '0) : (access && MEM_LATENCY == 0);
  assign stall    = (state == BUSY) ? (counter != '0) : (access && MEM_LATENCY != 0);
  assign memIndex = curReq.result[ADDR_WIDTH+1:2];
  // Reset must win over a completing store so an aborted access leaves RAM untouched.
  assign memWe    = complete & curReq.memCtl[MEMWRITE] & ~rst;

  data_memory #(.ADDR_WIDTH(ADDR_WIDTH)) uDataMemory (
    .clk        (clk),
    .writeEnable(memWe),
    .address    (memIndex),
    .writeData  (curReq.writeData),
    .readData   (ramData)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      state               <= IDLE;
      counter             <= '0;
      heldReq             <= '0;
      writeBackControlOut <= '0;
      readDataOut         <= '0;
      resultOut           <= '0;
      rdOut               <= '0;
    end else if (state == IDLE && access && MEM_LATENCY != 0) begin
      heldReq             <= inReq;
      counter             <= CNT_W'(MEM_LATENCY - 1);
      state               <= BUSY;
      writeBackControlOut <= '0;
      readDataOut         <= '0;
      resultOut           <= '0;
      rdOut               <= '0;
    end else if (state == BUSY && counter != '0) begin
      counter <= counter - CNT_W'(1);
    end else begin
      // Plain pass-through and access completion share the same MEM/WB load.
      state               <= IDLE;
      writeBackControlOut <= curReq.wbCtl;
      resultOut           <= curReq.result;
      rdOut               <= curReq.rd;
      readDataOut         <= (complete && curReq.memCtl[MEMREAD]) ? ramData : '0;
    end
  end

  assign memWbRegWrite = writeBackControlOut[REGWRITE];
  assign memWbRd       = rdOut;
  assign memWbData     = writeBackControlOut[MEMTOREG] ? readDataOut : resultOut;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: one instance at latency 2, one at latency 0.
module tb_memory_access_stage;

  logic        clk = 1'b1;
  logic        rst = 1'b0;
  logic [1:0]  wbIn = '0, memIn = '0;
  logic [31:0] resIn = '0, wdIn = '0;
  logic [4:0]  rdIn = '0;
  logic        stall;
  logic [1:0]  wbOut;
  logic [31:0] rdData, resOut, wbData;
  logic [4:0]  rdOut, wbRd;
  logic        wbRegWr;

  logic [1:0]  wbIn0 = '0, memIn0 = '0;
  logic [31:0] resIn0 = '0, wdIn0 = '0;
  logic [4:0]  rdIn0 = '0;
  logic        stall0;
  logic [1:0]  wbOut0;
  logic [31:0] rdData0, resOut0, wbData0;
  logic [4:0]  rdOut0, wbRd0;
  logic        wbRegWr0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.ADDR_WIDTH(8), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .writeBackControlIn(wbIn), .memAccessControlIn(memIn), .resultIn(resIn),
    .writeDataIn(wdIn), .rdIn(rdIn), .stall(stall),
    .writeBackControlOut(wbOut), .readDataOut(rdData), .resultOut(resOut),
    .rdOut(rdOut), .memWbRegWrite(wbRegWr), .memWbRd(wbRd), .memWbData(wbData)
  );

  memory_access_stage #(.ADDR_WIDTH(8), .MEM_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .writeBackControlIn(wbIn0), .memAccessControlIn(memIn0), .resultIn(resIn0),
    .writeDataIn(wdIn0), .rdIn(rdIn0), .stall(stall0),
    .writeBackControlOut(wbOut0), .readDataOut(rdData0), .resultOut(resOut0),
    .rdOut(rdOut0), .memWbRegWrite(wbRegWr0), .memWbRd(wbRd0), .memWbData(wbData0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Active edge is the falling edge; look 1ns after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [1:0] mem, input logic [31:0] res,
                       input logic [31:0] wd, input logic [4:0] rd);
    wbIn = wb; memIn = mem; resIn = res; wdIn = wd; rdIn = rd;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  // Full latency-2 access with EX/MEM held; returns just after the completion edge.
  task automatic doAccess(input string tag, input logic [1:0] wb, input logic [1:0] mem,
                          input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd);
    drive(wb, mem, res, wd, rd);
    check({tag, ".stallC0"}, 32'(stall), 32'd1);
    tick();
    check({tag, ".stallC1"}, 32'(stall), 32'd1);
    check({tag, ".bubbleWb"}, 32'(wbOut), 32'd0);
    check({tag, ".bubbleData"}, wbData, 32'd0);
    tick();
    check({tag, ".stallC2"}, 32'(stall), 32'd0);
    tick();
  endtask

  task automatic drive0(input logic [1:0] wb, input logic [1:0] mem, input logic [31:0] res,
                        input logic [31:0] wd, input logic [4:0] rd);
    wbIn0 = wb; memIn0 = mem; resIn0 = res; wdIn0 = wd; rdIn0 = rd;
    #1;
  endtask

  initial begin
    // 1: reset, then ALU pass-through
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.wbOut", 32'(wbOut), 32'd0);
    check("rst.readData", rdData, 32'd0);
    check("rst.result", resOut, 32'd0);
    check("rst.rd", 32'(rdOut), 32'd0);
    check("rst.memWbData", wbData, 32'd0);
    drive(2'b10, 2'b00, 32'h1234, 32'h0, 5'd5);
    check("alu.stallPre", 32'(stall), 32'd0);
    tick();
    check("alu.stallPost", 32'(stall), 32'd0);
    check("alu.rdOut", 32'(rdOut), 32'd5);
    check("alu.memWbRd", 32'(wbRd), 32'd5);
    check("alu.memWbData", wbData, 32'h1234);
    check("alu.regWrite", 32'(wbRegWr), 32'd1);
    check("alu.readData", rdData, 32'd0);

    // 2: store then load of the same word
    doAccess("st40", 2'b00, 2'b01, 32'h40, 32'hDEADBEEF, 5'd0);
    check("st40.readData", rdData, 32'd0);
    doAccess("ld40", 2'b11, 2'b10, 32'h40, 32'h0, 5'd7);
    check("ld40.readData", rdData, 32'hDEADBEEF);
    check("ld40.memWbData", wbData, 32'hDEADBEEF);
    check("ld40.rd", 32'(wbRd), 32'd7);
    check("ld40.regWrite", 32'(wbRegWr), 32'd1);
    idle();

    // 3: address wrap and ignored byte offset
    doAccess("st3fc", 2'b00, 2'b01, 32'h3FC, 32'hCAFE0001, 5'd0);
    doAccess("ldWrap", 2'b11, 2'b10, 32'h7FC, 32'h0, 5'd8);
    check("ldWrap.readData", rdData, 32'hCAFE0001);
    check("ldWrap.result", resOut, 32'h7FC);
    doAccess("ld41", 2'b11, 2'b10, 32'h41, 32'h0, 5'd0);
    check("ld41.readData", rdData, 32'hDEADBEEF);
    check("ld41.rdZero", 32'(wbRd), 32'd0);
    idle();

    // 4: reset during a busy store leaves RAM untouched
    doAccess("st10old", 2'b00, 2'b01, 32'h10, 32'h11, 5'd0);
    drive(2'b00, 2'b01, 32'h10, 32'h55, 5'd0);
    tick();
    check("abort.stallBusy", 32'(stall), 32'd1);
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    check("abort.stall", 32'(stall), 32'd0);
    check("abort.wbOut", 32'(wbOut), 32'd0);
    check("abort.result", resOut, 32'd0);
    check("abort.readData", rdData, 32'd0);
    doAccess("ld10", 2'b11, 2'b10, 32'h10, 32'h0, 5'd4);
    check("ld10.readData", rdData, 32'h11);
    idle();

    // 6: read+write together is a store returning the old word
    doAccess("st8", 2'b00, 2'b01, 32'h8, 32'h3, 5'd0);
    doAccess("rw8", 2'b11, 2'b11, 32'h8, 32'h7, 5'd9);
    check("rw8.readData", rdData, 32'h3);
    check("rw8.memWbData", wbData, 32'h3);
    doAccess("ld8", 2'b11, 2'b10, 32'h8, 32'h0, 5'd9);
    check("ld8.readData", rdData, 32'h7);
    idle();

    // 5: zero latency, back-to-back store/load pairs
    drive0(2'b00, 2'b01, 32'h20, 32'hA5, 5'd0);
    check("l0.st20.stall", 32'(stall0), 32'd0);
    tick();
    check("l0.st20.result", resOut0, 32'h20);
    drive0(2'b11, 2'b10, 32'h20, 32'h0, 5'd3);
    check("l0.ld20.stall", 32'(stall0), 32'd0);
    tick();
    check("l0.ld20.readData", rdData0, 32'hA5);
    check("l0.ld20.memWbData", wbData0, 32'hA5);
    check("l0.ld20.rd", 32'(wbRd0), 32'd3);
    drive0(2'b00, 2'b01, 32'h24, 32'h5A, 5'd0);
    check("l0.st24.stall", 32'(stall0), 32'd0);
    tick();
    check("l0.st24.wbOut", 32'(wbOut0), 32'd0);
    drive0(2'b11, 2'b10, 32'h24, 32'h0, 5'd6);
    check("l0.ld24.stall", 32'(stall0), 32'd0);
    tick();
    check("l0.ld24.memWbData", wbData0, 32'h5A);
    check("l0.ld24.regWrite", 32'(wbRegWr0), 32'd1);
    drive0(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    check("l0.idle.readData", rdData0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
